// File: rtl/serial_add_sub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: operation mode and
// controller states.
package serial_add_sub_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_add_sub_full_add_sub.sv
// One-bit full adder/subtractor cell; cout is carry for add, borrow for sub.
module full_add_sub
    import serial_add_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);
    logic w_xy;

    assign w_xy = x ^ y;
    assign s    = w_xy ^ cin;
    assign cout = (mode == MODE_SUB) ? ((~x & y) | (~w_xy & cin))
                                     : ((x & y) | (cin & w_xy));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one bit per clock, LSB first, through a single
// full_add_sub cell, with a start/busy/done handshake.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_add_sub: WIDTH must be >= 2");
        end
    endgenerate

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_mode, r_c, r_a_msb, r_b_msb, r_cout, r_ovf;
    logic             w_s, w_c, w_accept, w_last, w_beff_msb;
    logic [WIDTH-1:0] w_acc_next;

    full_add_sub u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .cin  (r_c),
        .mode (r_mode),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_accept   = start && (r_state != RUN);
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = {w_s, {(WIDTH-1){1'b0}}} | (r_acc >> 1);
    // Subtraction adds ~b, so overflow is judged against the effective sign of b.
    assign w_beff_msb = (r_mode == MODE_SUB) ? ~r_b_msb : r_b_msb;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mode   <= MODE_ADD;
            r_c      <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_c     <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_acc <= w_acc_next;
            r_c   <= w_c;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_acc_next;
                r_cout   <= w_c;
                r_ovf    <= (r_a_msb == w_beff_msb) && (w_s != r_a_msb);
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// Randomised and directed checks of serial_add_sub against an arithmetic model.
module tb_serial_add_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, ovf;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    // Reference: plain integer arithmetic, returns {ovf, cout, result}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic m);
        int ux, uy, sx, sy, ur, sr;
        logic [W-1:0] r;
        logic c, o;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W-1))) ? uy - (1 << W) : uy;
        if (m) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux < uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= (1 << W));
        end
        r = ur[W-1:0];
        o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return {o, c, r};
    endfunction

    // Issue one op and wait for done; lat is cycles from accept edge to done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                          output logic [W-1:0] r, output logic c, output logic o,
                          output int lat, output bit bok);
        @(negedge clk);
        a = x; b = y; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        bok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                lat = k;
                if (busy) bok = 1'b0;
                break;
            end
            if (!busy) bok = 1'b0;
            @(posedge clk); #1;
        end
        r = result; c = cout; o = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 1'b0; a = 8'hFF; b = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {cout, ovf}); end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{8'h3C, 8'hFF, 8'h10, 8'h80, 8'h05};
        logic [W-1:0] vb[5] = '{8'h45, 8'h01, 8'h20, 8'h01, 8'h05};
        logic         vm[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] er[5] = '{8'h81, 8'h00, 8'hF0, 8'h7F, 8'h00};
        logic         ec[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         eo[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] r;
        logic         c, o;
        int           lat;
        bit           bok;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vm[i], r, c, o, lat, bok);
            checks++; if (lat != W) begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W); end
            checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy: got gap want busy through RUN", i); end
            checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, r, er[i]); end
            checks++; if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_cout: got %b want %b", i, c, ec[i]); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b want %b", i, o, eo[i]); end
            @(posedge clk); #1;
            checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL dir%0d_idle: got %b want 00", i, {busy, done}); end
            checks++; if (result !== er[i]) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, result, er[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r;
        logic         m, c, o;
        logic [W+1:0] exp;
        int           lat;
        bit           bok;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            m = 1'($urandom);
            exp = model(x, y, m);
            run_op(x, y, m, r, c, o, lat, bok);
            checks++;
            if ({o, c, r} !== exp || lat != W || !bok) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h m=%b got r=%h c=%b o=%b lat=%0d want r=%h c=%b o=%b lat=%0d",
                         i, x, y, m, r, c, o, lat, exp[W-1:0], exp[W], exp[W+1], W);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] x, y;
        logic [W+1:0] exp;
        logic [W-1:0] rsave;
        int           ndone;
        x = 8'h5A; y = 8'hC3;
        exp = model(x, y, 1'b1);
        rsave = 'x;
        ndone = 0;
        @(negedge clk);
        a = x; b = y; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin ndone++; rsave = result; end
            if (k == 2) begin start = 1'b1; a = 8'h11; b = 8'h22; mode = 1'b0; end
            if (k == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        checks++; if (rsave !== exp[W-1:0]) begin errors++; $display("FAIL ignore_result: got %h want %h", rsave, exp[W-1:0]); end
    endtask

    task automatic test_back_to_back();
        int           d1, d2;
        logic [W-1:0] r1, r2;
        d1 = -1; d2 = -1; r1 = 'x; r2 = 'x;
        @(negedge clk);
        a = 8'h3C; b = 8'h45; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h01; b = 8'h02;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                if (d1 < 0) begin d1 = k; r1 = result; end
                else if (d2 < 0) begin d2 = k; r2 = result; end
            end
            if (d1 >= 0 && k == d1 + 1) begin
                start = 1'b0;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
            end
            if (d1 >= 0 && k == d1 + 4) begin
                checks++; if (result !== 8'h81) begin errors++; $display("FAIL b2b_hold: got %h want 81", result); end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (d1 != W) begin errors++; $display("FAIL b2b_first_done: got %0d want %0d", d1, W); end
        checks++; if (d2 - d1 != W + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", d2 - d1, W + 1); end
        checks++; if (r1 !== 8'h81) begin errors++; $display("FAIL b2b_result1: got %h want 81", r1); end
        checks++; if (r2 !== 8'h03) begin errors++; $display("FAIL b2b_result2: got %h want 03", r2); end
    endtask

    task automatic test_reset_mid_run();
        int           ndone;
        logic [W-1:0] r;
        logic         c, o;
        int           lat;
        bit           bok;
        logic [W+1:0] exp;
        ndone = 0;
        @(negedge clk);
        a = 8'h7F; b = 8'h7F; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                rst = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy: got %b want 0", busy); end
                checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstrun_result: got %h want 00", result); end
                checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL rstrun_flags: got %b want 00", {cout, ovf}); end
            end
            if (done) ndone++;
            @(posedge clk); #1;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstrun_no_done: got %0d want 0", ndone); end
        exp = model(8'h7F, 8'h7F, 1'b0);
        run_op(8'h7F, 8'h7F, 1'b0, r, c, o, lat, bok);
        checks++;
        if ({o, c, r} !== exp || lat != W) begin
            errors++;
            $display("FAIL rstrun_after: got r=%h c=%b o=%b lat=%0d want r=%h c=%b o=%b lat=%0d",
                     r, c, o, lat, exp[W-1:0], exp[W], exp[W+1], W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
